reset_sequencer: RTL and testbench

//   Sequences reset release for NUM_DOMAINS downstream reset domains.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_wdt.sv | 30 +++
 rtl/reset_sequencer.sv | 103 ++++++++++
 tb/tb_reset_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its watchdog.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_EXT = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } rst_cause_t;

  // Wide enough to count up to the longer of the hold and stagger intervals.
  function automatic int seq_cnt_width(input int hold_cycles, input int stagger_cycles);
    int longest;
    longest = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/reset_wdt.sv
// Watchdog counter: counts while enabled, restarts on kick or clear,
// and flags expiry when the limit is reached without a kick.
module reset_wdt #(
  parameter int                   WDT_WIDTH = 16,
  parameter logic [WDT_WIDTH-1:0] WDT_LIMIT = {WDT_WIDTH{1'b1}}
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  input  logic clr,
  output logic expire
);

  logic [WDT_WIDTH-1:0] cnt;

  // Kick beats expiry; clear and disable both pin the counter at zero.
  assign expire = en && !kick && !clr && (cnt == WDT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || kick || !en || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset release for NUM_DOMAINS domains, with software and
// watchdog re-entry into the sequence and a sticky last-reset cause.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                   NUM_DOMAINS    = 3,
  parameter int                   HOLD_CYCLES    = 8,
  parameter int                   STAGGER_CYCLES = 4,
  parameter int                   WDT_WIDTH      = 16,
  parameter logic [WDT_WIDTH-1:0] WDT_LIMIT      = {WDT_WIDTH{1'b1}}
) (
  input  logic                   CLK,
  input  logic                   RST_IN,
  input  logic                   SW_RST_REQ,
  input  logic                   WDT_EN,
  input  logic                   WDT_KICK,
  output logic [NUM_DOMAINS-1:0] RST_OUT,
  output logic                   READY,
  output logic [1:0]             CAUSE
);

  localparam int CW = seq_cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] ALL_RELEASED = IW'(NUM_DOMAINS);

  seq_state_t    state;
  logic [CW-1:0] seq_cnt;
  logic [IW-1:0] released;
  logic          wdt_clr;
  logic          wdt_expire;
  logic          wdt_event;

  // A software request also clears the watchdog so it restarts from zero.
  assign wdt_clr   = (state != RUN) || SW_RST_REQ;
  assign wdt_event = (state == RUN) && wdt_expire;

  reset_wdt #(
    .WDT_WIDTH (WDT_WIDTH),
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk    (CLK),
    .rst    (RST_IN),
    .en     (WDT_EN),
    .kick   (WDT_KICK),
    .clr    (wdt_clr),
    .expire (wdt_expire)
  );

  // RST_OUT shifts in zeros from bit 0, so it stays a thermometer code.
  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      state    <= HOLD;
      seq_cnt  <= '0;
      released <= '0;
      RST_OUT  <= '1;
      READY    <= 1'b0;
      CAUSE    <= CAUSE_EXT;
    end else if (SW_RST_REQ || wdt_event) begin
      state    <= HOLD;
      seq_cnt  <= '0;
      released <= '0;
      RST_OUT  <= '1;
      READY    <= 1'b0;
      CAUSE    <= SW_RST_REQ ? CAUSE_SW : CAUSE_WDT;
    end else begin
      case (state)
        HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            RST_OUT  <= RST_OUT << 1;
            released <= IW'(1);
            seq_cnt  <= '0;
            state    <= RELEASE;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (released == ALL_RELEASED) begin
            READY   <= 1'b1;
            seq_cnt <= '0;
            state   <= RUN;
          end else if (seq_cnt == STAGGER_LAST) begin
            RST_OUT  <= RST_OUT << 1;
            released <= released + 1'b1;
            seq_cnt  <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        RUN: begin
          seq_cnt <= '0;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, software and watchdog
// re-entry, simultaneous events, mid-sequence restarts and async reset.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RST_IN = 1'b0;
  logic       SW_RST_REQ = 1'b0;
  logic       WDT_EN = 1'b0;
  logic       WDT_KICK = 1'b0;
  logic [2:0] RST_OUT;
  logic       READY;
  logic [1:0] CAUSE;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS    (3),
    .HOLD_CYCLES    (8),
    .STAGGER_CYCLES (4),
    .WDT_WIDTH      (16),
    .WDT_LIMIT      (16'd20)
  ) dut (
    .CLK        (CLK),
    .RST_IN     (RST_IN),
    .SW_RST_REQ (SW_RST_REQ),
    .WDT_EN     (WDT_EN),
    .WDT_KICK   (WDT_KICK),
    .RST_OUT    (RST_OUT),
    .READY      (READY),
    .CAUSE      (CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic therm_ok(input logic [2:0] v);
    return (v == 3'b111) || (v == 3'b110) || (v == 3'b100) || (v == 3'b000);
  endfunction

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Caller has just passed "edge 0"; walks edges 1..17 of a full release.
  task automatic seq_check(input logic [1:0] cause_exp);
    logic [2:0] r;
    for (int e = 1; e <= 17; e++) begin
      edges(1);
      r = (e < 8) ? 3'b111 : (e < 12) ? 3'b110 : (e < 16) ? 3'b100 : 3'b000;
      check("seq_rst_out", {29'd0, RST_OUT}, {29'd0, r});
      check("seq_ready", {31'd0, READY}, {31'd0, (e >= 17)});
      check("seq_therm", {31'd0, therm_ok(RST_OUT)}, 32'd1);
    end
    check("seq_cause", {30'd0, CAUSE}, {30'd0, cause_exp});
  endtask

  initial begin
    logic lost;

    // Power-up reset, observed without any clock edge
    #1 RST_IN = 1'b1;
    #1;
    check("por_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("por_ready", {31'd0, READY}, 32'd0);
    check("por_cause", {30'd0, CAUSE}, 32'd0);
    edges(2);
    @(negedge CLK) RST_IN = 1'b0;
    seq_check(2'b00);

    // Watchdog disabled: RUN holds indefinitely
    edges(40);
    check("wdt_off_ready", {31'd0, READY}, 32'd1);

    // Single-cycle software request in RUN
    @(negedge CLK) SW_RST_REQ = 1'b1;
    edges(1);
    SW_RST_REQ = 1'b0;
    check("sw_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("sw_ready", {31'd0, READY}, 32'd0);
    check("sw_cause", {30'd0, CAUSE}, 32'd1);
    seq_check(2'b01);

    // Watchdog expiry 21 edges into RUN
    WDT_EN = 1'b1;
    edges(20);
    check("wdt_pre_ready", {31'd0, READY}, 32'd1);
    edges(1);
    check("wdt_ready", {31'd0, READY}, 32'd0);
    check("wdt_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("wdt_cause", {30'd0, CAUSE}, 32'd2);
    seq_check(2'b10);

    // Kick every 10 edges keeps RUN alive
    lost = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      WDT_KICK = (k % 10 == 0);
      edges(1);
      if (!READY) lost = 1'b1;
    end
    WDT_KICK = 1'b0;
    check("kick_no_reset", {31'd0, lost}, 32'd0);

    // Software request on the expiry cycle wins
    edges(20);
    check("sim_pre_ready", {31'd0, READY}, 32'd1);
    SW_RST_REQ = 1'b1;
    edges(1);
    SW_RST_REQ = 1'b0;
    check("sim_sw_cause", {30'd0, CAUSE}, 32'd1);
    check("sim_sw_ready", {31'd0, READY}, 32'd0);
    check("sim_sw_rst_out", {29'd0, RST_OUT}, 32'h7);
    seq_check(2'b01);

    // Kick on the expiry cycle: no reset, counter restarts from 0
    edges(20);
    WDT_KICK = 1'b1;
    edges(1);
    WDT_KICK = 1'b0;
    check("kick_wins_ready", {31'd0, READY}, 32'd1);
    edges(20);
    check("kick_restart_ready", {31'd0, READY}, 32'd1);
    edges(1);
    check("kick_restart_expire", {31'd0, READY}, 32'd0);
    check("kick_restart_cause", {30'd0, CAUSE}, 32'd2);
    seq_check(2'b10);
    WDT_EN = 1'b0;

    // Software request held high keeps everything in HOLD
    SW_RST_REQ = 1'b1;
    edges(20);
    check("sw_held_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("sw_held_ready", {31'd0, READY}, 32'd0);
    check("sw_held_cause", {30'd0, CAUSE}, 32'd1);
    SW_RST_REQ = 1'b0;
    seq_check(2'b01);

    // Mid-sequence restart at edge 13
    SW_RST_REQ = 1'b1;
    edges(1);
    SW_RST_REQ = 1'b0;
    edges(12);
    check("mid_before", {29'd0, RST_OUT}, 32'h4);
    SW_RST_REQ = 1'b1;
    edges(1);
    SW_RST_REQ = 1'b0;
    check("mid_restart", {29'd0, RST_OUT}, 32'h7);
    check("mid_cause", {30'd0, CAUSE}, 32'd1);
    seq_check(2'b01);

    // Async reset mid-RELEASE
    SW_RST_REQ = 1'b1;
    edges(1);
    SW_RST_REQ = 1'b0;
    edges(10);
    check("async_rel_before", {29'd0, RST_OUT}, 32'h6);
    #2 RST_IN = 1'b1;
    #1;
    check("async_rel_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("async_rel_ready", {31'd0, READY}, 32'd0);
    check("async_rel_cause", {30'd0, CAUSE}, 32'd0);
    @(negedge CLK) RST_IN = 1'b0;
    seq_check(2'b00);

    // Async reset mid-RUN
    edges(5);
    check("async_run_before", {31'd0, READY}, 32'd1);
    #2 RST_IN = 1'b1;
    #1;
    check("async_run_rst_out", {29'd0, RST_OUT}, 32'h7);
    check("async_run_ready", {31'd0, READY}, 32'd0);
    check("async_run_cause", {30'd0, CAUSE}, 32'd0);
    @(negedge CLK) RST_IN = 1'b0;
    seq_check(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
